// File: rtl/rs_pkg.sv
// Shared RS(255,239) definitions over GF(2^8): field polynomial, code sizes, generator
// coefficients (also used by the decoder syndrome block) and the encoder state enum.
package rs_pkg;

    localparam logic [7:0] GF_POLY = 8'h1D;
    localparam int         RS_N    = 255;
    localparam int         RS_K    = 239;
    localparam int         RS_2T   = RS_N - RS_K;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x^2+1 on every carry out of bit 7.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return acc;
    endfunction

    // g(x) = prod_{i=0}^{2T-1} (x + alpha^i), alpha = 0x02; returns g[0..2T-1] packed, g[2T]=1 implied.
    function automatic logic [RS_2T*8-1:0] rs_gen_calc();
        logic [7:0]         g [0:RS_2T];
        logic [7:0]         root;
        logic [RS_2T*8-1:0] flat;
        for (int j = 0; j <= RS_2T; j++) g[j] = 8'h00;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < RS_2T; i++) begin
            for (int j = RS_2T; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
        flat = '0;
        for (int j = 0; j < RS_2T; j++) flat[j*8 +: 8] = g[j];
        return flat;
    endfunction

    localparam logic [RS_2T*8-1:0] RS_GEN_FLAT = rs_gen_calc();

    localparam logic [7:0] RS_GEN [0:15] = '{
        RS_GEN_FLAT[  7:  0], RS_GEN_FLAT[ 15:  8], RS_GEN_FLAT[ 23: 16], RS_GEN_FLAT[ 31: 24],
        RS_GEN_FLAT[ 39: 32], RS_GEN_FLAT[ 47: 40], RS_GEN_FLAT[ 55: 48], RS_GEN_FLAT[ 63: 56],
        RS_GEN_FLAT[ 71: 64], RS_GEN_FLAT[ 79: 72], RS_GEN_FLAT[ 87: 80], RS_GEN_FLAT[ 95: 88],
        RS_GEN_FLAT[103: 96], RS_GEN_FLAT[111:104], RS_GEN_FLAT[119:112], RS_GEN_FLAT[127:120]
    };

endpackage

// File: rtl/gf_const_mult.sv
// Combinational GF(2^8) multiply by a fixed coefficient; collapses to an XOR network.
module gf_const_mult
    import rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = gf_mul(a, COEF);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder: message passes through with one cycle latency, then 2T parity.
// Build option RS_ENC_SHORTEN_EN: an accepted in_eop ends the message early (shortened code).
module rs_encoder
    import rs_pkg::*;
#(
    parameter int N = RS_N,
    parameter int K = RS_K
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_parity,
    output logic [7:0] out_data
);

    localparam int T2 = N - K;

    state_t     state;
    logic       ready;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] p    [0:T2-1];
    logic [7:0] prod [0:T2-1];
    logic [7:0] fb;
    logic       take;
    logic       last;

    assign in_ready = ready;
    assign take     = in_valid & ready & (in_sop | (state == DATA));
    assign cnt_next = in_sop ? 8'd1 : cnt + 8'd1;
    // An in_sop symbol always starts from a zero LFSR, which also covers mid-message aborts.
    assign fb       = in_data ^ (in_sop ? 8'h00 : p[T2-1]);

`ifdef RS_ENC_SHORTEN_EN
    assign last = (cnt_next == 8'(K)) || in_eop;
`else
    logic unused_eop;
    assign unused_eop = in_eop;
    assign last = (cnt_next == 8'(K));
`endif

    for (genvar i = 0; i < T2; i++) begin : g_mult
        gf_const_mult #(.COEF(RS_GEN[i])) u_gmul (
            .a (fb),
            .y (prod[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            cnt        <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_parity <= 1'b0;
            out_data   <= 8'h00;
            for (int i = 0; i < T2; i++) p[i] <= 8'h00;
        end else begin
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_parity <= 1'b0;
            case (state)
                IDLE, DATA: begin
                    if (take) begin
                        out_valid <= 1'b1;
                        out_sop   <= in_sop;
                        out_data  <= in_data;
                        p[0]      <= prod[0];
                        for (int i = 1; i < T2; i++)
                            p[i] <= (in_sop ? 8'h00 : p[i-1]) ^ prod[i];
                        if (last) begin
                            state <= PARITY;
                            ready <= 1'b0;
                            cnt   <= 8'd0;
                        end else begin
                            state <= DATA;
                            cnt   <= cnt_next;
                        end
                    end
                end
                PARITY: begin
                    // Highest-order remainder symbol leaves first; register shifts up with zero fill.
                    out_valid  <= 1'b1;
                    out_parity <= 1'b1;
                    out_data   <= p[T2-1];
                    p[0]       <= 8'h00;
                    for (int i = 1; i < T2; i++) p[i] <= p[i-1];
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(T2 - 1)) begin
                        state   <= IDLE;
                        ready   <= 1'b1;
                        out_eop <= 1'b1;
                        cnt     <= 8'd0;
                        for (int i = 0; i < T2; i++) p[i] <= 8'h00;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: independent log-table GF model, long-division parity, syndromes.
module tb_rs_encoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_parity;
    logic [7:0] out_data;

    rs_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_parity (out_parity),
        .out_data   (out_data)
    );

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       p;
        int         cyc;
    } rec_t;

    rec_t       q [$];
    int         cyc = 0;
    int         rdy_low = 0;
    int         n_chk;
    int         n_pass;
    int         gexp [0:254];
    int         glog [0:255];
    logic [7:0] gtb  [0:16];
    logic [7:0] msg  [0:1][0:238];
    logic [7:0] par  [0:15];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && out_valid) q.push_back('{out_data, out_sop, out_eop, out_parity, cyc});
        if (reset && !in_ready) rdy_low <= rdy_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[(glog[a] + glog[b]) % 255]);
    endfunction

    task automatic build_tables();
        gexp[0] = 1;
        for (int i = 1; i < 255; i++) begin
            gexp[i] = gexp[i-1] << 1;
            if (gexp[i] > 255) gexp[i] = gexp[i] ^ 32'h11D;
        end
        for (int i = 0; i < 255; i++) glog[gexp[i]] = i;
        glog[0] = 0;
        for (int j = 0; j <= 16; j++) gtb[j] = 8'h00;
        gtb[0] = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) gtb[j] = gtb[j-1] ^ tmul(gtb[j], 8'(gexp[i]));
            gtb[0] = tmul(gtb[0], 8'(gexp[i]));
        end
    endtask

    // Remainder of m(x)*x^16 by g(x) through polynomial long division over the full 239 symbols.
    task automatic model_parity(input int slot);
        logic [7:0] b [0:254];
        for (int k = 0; k < 255; k++) b[k] = (k < 239) ? msg[slot][k] : 8'h00;
        for (int i = 0; i < 239; i++)
            if (b[i] != 8'h00)
                for (int j = 1; j <= 16; j++) b[i+j] = b[i+j] ^ tmul(b[i], gtb[16-j]);
        for (int k = 0; k < 16; k++) par[k] = b[239+k];
    endtask

    task automatic drive_msg(input int slot, input int start, input int len, input bit stall,
                             input int eop_idx);
        int b;
        for (int i = 0; i < len; i++) begin
            if (stall && i > 0)
                while ($urandom_range(1) == 0) begin
                    in_valid = 1'b0;
                    step();
                    chk("stall_quiet", 32'(out_valid), 32'd0);
                end
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
            b = 0;
            while (!in_ready && b < 100) begin
                step();
                b++;
            end
            if (!in_ready) chk("ready_wait", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_sop   = (i == 0);
            in_eop   = (i == eop_idx);
            in_data  = msg[slot][start+i];
            step();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (q.size() < n && b < 3000) begin
            step();
            b++;
        end
        chk("wait_out", 32'(q.size() >= n), 32'd1);
    endtask

    task automatic check_cw(input string tag, input int slot, input int start, input int len,
                            input bit syn, output int sop_cyc, output int eop_cyc,
                            output int last_cyc);
        rec_t       r;
        logic [7:0] cw [0:254];
        logic [7:0] s;
        logic [7:0] e;
        sop_cyc  = -1;
        eop_cyc  = -1;
        last_cyc = -1;
        model_parity(slot);
        chk({tag, "_len"}, 32'(q.size() >= len + 16), 32'd1);
        if (q.size() < len + 16) return;
        for (int k = 0; k < len + 16; k++) begin
            r = q.pop_front();
            e = (k < len) ? msg[slot][start+k] : par[k-len];
            chk({tag, "_data"}, 32'(r.d), 32'(e));
            chk({tag, "_flags"}, 32'({r.s, r.e, r.p}),
                32'({(k == 0), (k == len + 15), (k >= len)}));
            cw[255-len-16+k] = r.d;
            if (k == 0) sop_cyc = r.cyc;
            if (k == len - 1) last_cyc = r.cyc;
            if (k == len + 15) eop_cyc = r.cyc;
        end
        if (syn)
            for (int i = 0; i < 16; i++) begin
                s = 8'h00;
                for (int k = 0; k < 255; k++) s = tmul(s, 8'(gexp[i])) ^ cw[k];
                chk({tag, "_syndrome"}, 32'(s), 32'd0);
            end
    endtask

    task automatic fill(input int slot, input bit rnd);
        for (int k = 0; k < 239; k++) msg[slot][k] = rnd ? 8'($urandom_range(255)) : 8'h00;
    endtask

    initial begin
        int   sa, ea, la, sb, eb, lb, low0;
        rec_t r;
        n_chk    = 0;
        n_pass   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h00;
        build_tables();
        repeat (3) step();
        chk("rst_valid",  32'(out_valid),  32'd0);
        chk("rst_sop",    32'(out_sop),    32'd0);
        chk("rst_eop",    32'(out_eop),    32'd0);
        chk("rst_parity", 32'(out_parity), 32'd0);
        chk("rst_data",   32'(out_data),   32'd0);
        chk("rst_ready",  32'(in_ready),   32'd1);
        reset = 1'b1;
        step();
        for (int i = 0; i < 16; i++) chk("rs_gen", 32'(rs_pkg::RS_GEN[i]), 32'(gtb[i]));

        // Symbols without in_sop while idle are dropped.
        in_valid = 1'b1;
        in_data  = 8'hAB;
        step();
        in_valid = 1'b0;
        chk("idle_drop", 32'(out_valid), 32'd0);

        fill(0, 1'b0);
        drive_msg(0, 0, 239, 1'b0, -1);
        wait_out(255);
        check_cw("zero", 0, 0, 239, 1'b1, sa, ea, la);
        repeat (3) step();
        chk("zero_extra", 32'(q.size()), 32'd0);

        fill(0, 1'b0);
        msg[0][238] = 8'h01;
        drive_msg(0, 0, 239, 1'b0, -1);
        wait_out(255);
        check_cw("impulse", 0, 0, 239, 1'b0, sa, ea, la);
        chk("impulse_p15", 32'(par[0]), 32'(gtb[15]));

        fill(0, 1'b1);
        drive_msg(0, 0, 239, 1'b1, -1);
        wait_out(255);
        check_cw("rand_stall", 0, 0, 239, 1'b1, sa, ea, la);
        repeat (3) step();

        fill(0, 1'b1);
        fill(1, 1'b1);
        low0 = rdy_low;
        drive_msg(0, 0, 239, 1'b0, -1);
        drive_msg(1, 0, 239, 1'b0, -1);
        wait_out(510);
        check_cw("b2b_a", 0, 0, 239, 1'b1, sa, ea, la);
        check_cw("b2b_b", 1, 0, 239, 1'b1, sb, eb, lb);
        chk("b2b_gap", 32'(sb - ea), 32'd1);
        chk("b2b_tail", 32'(ea - la), 32'd16);
        step();
        chk("b2b_ready_low", 32'(rdy_low - low0), 32'd32);

        fill(0, 1'b1);
        drive_msg(0, 0, 100, 1'b0, -1);
        step();
        reset = 1'b0;
        #2;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b1;
        repeat (30) step();
        chk("midrst_count", 32'(q.size()), 32'd100);
        while (q.size() > 0) begin
            r = q.pop_front();
            chk("midrst_noparity", 32'(r.p), 32'd0);
        end
        fill(0, 1'b1);
        drive_msg(0, 0, 239, 1'b0, -1);
        wait_out(255);
        check_cw("after_rst", 0, 0, 239, 1'b1, sa, ea, la);

`ifdef RS_ENC_SHORTEN_EN
        fill(0, 1'b0);
        for (int k = 229; k < 239; k++) msg[0][k] = 8'($urandom_range(255));
        drive_msg(0, 229, 10, 1'b0, 9);
        wait_out(26);
        check_cw("short10", 0, 229, 10, 1'b1, sa, ea, la);
        fill(0, 1'b0);
        msg[0][238] = 8'h5A;
        drive_msg(0, 238, 1, 1'b0, 0);
        wait_out(17);
        check_cw("short1", 0, 238, 1, 1'b1, sa, ea, la);
`else
        fill(0, 1'b1);
        drive_msg(0, 0, 239, 1'b0, 9);
        wait_out(255);
        check_cw("eop_ignored", 0, 0, 239, 1'b1, sa, ea, la);
`endif
        repeat (5) step();
        chk("final_quiet", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic Reed-Solomon RS(N,K) encoder over GF(2^8), the transmit-side counterpart of the Euclidean decoder chain (syndrome, key-equation, Chien/Forney). It accepts a message symbol stream and passes each symbol through with one cycle of latency, running a 2T-stage LFSR division by g(x). After the last message symbol it appends the 2T parity symbols as a contiguous tail. The output is a full codeword stream that the decoder chain accepts directly.

## Interface
- N, 255, codeword length in symbols.
- K, 239, message length in symbols; 2T = N-K = 16 parity symbols.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a message symbol.
- in_sop  input  1  first symbol of a message; qualified by in_valid.
- in_eop  input  1  last symbol of a shortened message; used only with RS_ENC_SHORTEN_EN.
- in_data  input  8  message symbol.
- in_ready  output  1  encoder accepts a symbol this cycle.
- out_valid  output  1  out_data is valid.
- out_sop  output  1  first codeword symbol.
- out_eop  output  1  last parity symbol.
- out_parity  output  1  out_data is a parity symbol.
- out_data  output  8  codeword symbol.

## Operation
- Field polynomial: x^8+x^4+x^3+x^2+1 (0x11D).
- Generator: g(x) = prod_{i=0}^{2T-1}(x - alpha^i), with coefficients g[0..2T-1]; the leading coefficient is 1 and implicit.
- A symbol is accepted when in_valid & in_ready.
- FSM states:
  - IDLE: in_ready=1. An accepted symbol with in_sop moves to DATA. Accepted symbols without in_sop are dropped.
  - DATA: in_ready=1.
  - PARITY: in_ready=0.
- LFSR update, per accepted symbol only:
  - fb = in_data ^ p[2T-1].
  - p[0] <= g[0]·fb.
  - p[i] <= p[i-1] ^ g[i]·fb for i = 1..2T-1.
- On an in_sop symbol, the LFSR is treated as zero before the update.
- Symbol counter: 0..K-1 during DATA. When the K-th symbol is accepted, go to PARITY.
- PARITY: lasts exactly 2T cycles.
  - Each cycle, out_data <= p[2T-1] and p shifts up with zero fill. Parity is emitted highest-order first.
  - At the end of PARITY, return to IDLE with the LFSR cleared.
- in_valid low during DATA is a stall: LFSR and counter hold, out_valid=0.
- in_sop accepted mid-message in DATA aborts the current message: no parity is emitted, LFSR and counter restart, and that symbol becomes the new first symbol with out_sop=1.
- All GF arithmetic is 8-bit; addition is XOR.

## Timing
- Every output is reset to 0: out_valid, out_sop, out_eop, out_parity, out_data. The LFSR, counter and FSM (IDLE) are also cleared. in_ready is 1 out of reset.
- Data latency: a symbol accepted in cycle t appears on out_data at t+1, with out_sop copied from in_sop.
- Last message symbol accepted in cycle t:
  - in_ready=0 in cycles t+1 .. t+2T.
  - Parity symbols appear in cycles t+2 .. t+2T+1, with out_parity=1.
  - out_eop=1 at t+2T+1.
  - in_ready=1 again at t+2T+1. A symbol accepted then appears at t+2T+2, so back-to-back codewords are gapless.
- The output has no backpressure; the downstream consumer must always accept.
- Reset asserted mid-codeword: the partial codeword is discarded and no further outputs are produced until a new in_sop.

## Configuration
- RS_ENC_SHORTEN_EN, defined:
  - in_eop accepted in DATA ends the message at any count from 1 to K; PARITY follows immediately.
  - in_sop & in_eop on the same symbol gives a 1-symbol message.
  - Reaching K symbols without in_eop still ends the message.
- RS_ENC_SHORTEN_EN, undefined: in_eop is ignored and the message is always exactly K symbols.

## Structure
- Package rs_pkg:
  - GF_POLY = 8'h1D.
  - Default N and K.
  - RS_GEN[0:15], the generator coefficients, shared with the decoder syndrome block.
  - FSM state enum {IDLE, DATA, PARITY}.
- One sub-module, gf_const_mult: a combinational GF(2^8) multiplier by a parameter constant. Instantiate it 2T times, one per g[i].
- FSM, counter, LFSR and output register live in rs_encoder.

## Test plan
- All-zero message, 239 symbols -> out_data passes 239 zeros, then 16 parity zeros. out_sop on the first output, out_eop on the 255th.
- Message of zeros except the last symbol = 0x01 -> parity symbols equal RS_GEN[15], RS_GEN[14], ... RS_GEN[0], in that order.
- Random message, with in_valid toggled 50% during DATA -> codeword matches the software model, syndromes S0..S15 = 0, and there is no output during stalls.
- Two back-to-back messages -> second out_sop lands in the cycle after the first out_eop; in_ready low for exactly 16 cycles between them.
- Reset pulsed at symbol 100, then a new message -> no parity from the aborted message; the new codeword is correct.
- With RS_ENC_SHORTEN_EN: a 10-symbol message with in_eop -> 26-symbol output whose parity equals the full-length encoding of 229 zero symbols followed by the 10 symbols.
